// File: rtl/bad_point_lut_writer_pkg.sv
// Shared definitions for the bad-point LUT writer.
//   VCNT_LSB / HCNT_LSB : bit offsets of the row/column fields in a LUT word
//   ADDR_STRIDE         : byte distance between consecutive LUT entries
//   bp_state_e          : capture/drain FSM states
package bad_point_lut_writer_pkg;

  localparam int VCNT_LSB    = 16;
  localparam int HCNT_LSB    = 0;
  localparam int ADDR_STRIDE = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_DRAIN,
    ST_DONE
  } bp_state_e;

endpackage

// File: rtl/bad_point_lut_writer_if.sv
// LUT write channel: one entry per transfer, a transfer happens when
// wen_lut && wr_ready.
//   master : drives wen_lut, waddr_lut (byte address), wdata_lut; samples wr_ready
//   slave  : the LUT side, drives wr_ready
interface bad_point_lut_writer_if #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32
);
  logic                      wen_lut;
  logic [AXI_ADDR_WIDTH-1:0] waddr_lut;
  logic [AXI_DATA_WIDTH-1:0] wdata_lut;
  logic                      wr_ready;

  modport master (output wen_lut, output waddr_lut, output wdata_lut, input wr_ready);
  modport slave  (input wen_lut, input waddr_lut, input wdata_lut, output wr_ready);
endinterface

// File: rtl/bad_point_lut_writer_bp_coord_fifo.sv
// First-word-fall-through coordinate buffer. dout_o is the head entry and is
// valid whenever empty_o is low. Push and pop in the same cycle are both
// honoured, also when full. DEPTH must be a power of two so the pointers wrap
// naturally.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   push_i, din_i  : write request and data
//   pop_i          : remove head (ignored when empty)
//   dout_o         : head entry
//   full_o, empty_o: occupancy flags from the registered count
module bp_coord_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PW-1:0]               wr_ptr_q, rd_ptr_q;
  logic [PW:0]                 cnt_q;
  logic                        do_push, do_pop;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign dout_o  = mem_q[rd_ptr_q];

  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/bad_point_lut_writer.sv
// Bad-point LUT writer: records coordinates of defective pixels over one armed
// frame and streams them, in raster order, as LUT writes at index*4. When the
// buffer has drained, done pulses and bad_point_num holds the entry count.
//   aclk, areset        : clock, asynchronous active-high reset
//   arm                 : request to capture the next frame (IDLE only)
//   frame_start/end     : frame boundary pulses
//   in_valid, in_hcnt,
//   in_vcnt, defect_flag: pixel stream with defect marker
//   lut                 : LUT write channel (master side)
//   bad_point_num       : entries written by the last completed capture
//   busy, done, overflow: status (overflow is sticky per capture)
module bad_point_lut_writer
  import bad_point_lut_writer_pkg::*;
#(
  parameter int CNT_WIDTH      = 10,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int MAX_BP         = 128,
  parameter int BP_BIT         = 7,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 arm,
  input  logic                 frame_start,
  input  logic                 frame_end,
  input  logic                 in_valid,
  input  logic [CNT_WIDTH-1:0] in_hcnt,
  input  logic [CNT_WIDTH-1:0] in_vcnt,
  input  logic                 defect_flag,
  bad_point_lut_writer_if.master lut,
  output logic [7:0]           bad_point_num,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
);
  localparam int CW = BP_BIT + 1;

  bp_state_e state_q, state_d;
  logic [CW-1:0] acc_cnt_q, acc_cnt_d;
  logic [CW-1:0] wr_idx_q, wr_idx_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    num_q, num_d;

  logic                   start, eligible;
  logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [2*CNT_WIDTH-1:0] fifo_din, fifo_dout;
  logic                   wen;
  logic [AXI_DATA_WIDTH-1:0] wdata;

  assign fifo_din = {in_vcnt, in_hcnt};

  bp_coord_fifo #(
    .WIDTH (2*CNT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (aclk),
    .rst_i   (areset),
    .push_i  (fifo_push),
    .din_i   (fifo_din),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // wen follows the FIFO's registered empty flag, so an async reset of the
  // FIFO drops it immediately, mid-transfer included.
  assign wen      = !fifo_empty && (state_q == ST_CAPTURE || state_q == ST_DRAIN);
  assign fifo_pop = wen && lut.wr_ready;

  always_comb begin
    wdata = '0;
    wdata[VCNT_LSB +: CNT_WIDTH] = fifo_dout[2*CNT_WIDTH-1 -: CNT_WIDTH];
    wdata[HCNT_LSB +: CNT_WIDTH] = fifo_dout[CNT_WIDTH-1:0];
  end

  assign lut.wen_lut   = wen;
  assign lut.waddr_lut = AXI_ADDR_WIDTH'(wr_idx_q) * AXI_ADDR_WIDTH'(ADDR_STRIDE);
  assign lut.wdata_lut = wdata;

  always_comb begin
    state_d   = state_q;
    acc_cnt_d = acc_cnt_q;
    wr_idx_d  = wr_idx_q;
    ovf_d     = ovf_q;
    num_d     = num_q;
    start     = 1'b0;
    eligible  = 1'b0;
    fifo_push = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          start = 1'b1;
          if (frame_start) begin
            state_d  = ST_CAPTURE;
            eligible = 1'b1;
          end else begin
            state_d = ST_ARMED;
          end
        end
      end
      ST_ARMED: begin
        if (frame_start) begin
          start    = 1'b1;
          eligible = 1'b1;
          state_d  = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        eligible = 1'b1;
        if (frame_end) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Empty means nothing is presented, so the index is final here.
        if (fifo_empty) begin
          state_d = ST_DONE;
          num_d   = 8'(wr_idx_q);
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (start) begin
      acc_cnt_d = '0;
      wr_idx_d  = '0;
      ovf_d     = 1'b0;
    end

    // Uses the pre-pop full flag: a defect meeting a full FIFO is dropped
    // even if the head leaves in the same cycle.
    if (eligible && in_valid && defect_flag) begin
      if (acc_cnt_d < CW'(MAX_BP) && !fifo_full) begin
        fifo_push = 1'b1;
        acc_cnt_d = acc_cnt_d + CW'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end

    if (fifo_pop) wr_idx_d = wr_idx_d + CW'(1);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= ST_IDLE;
      acc_cnt_q <= '0;
      wr_idx_q  <= '0;
      ovf_q     <= 1'b0;
      num_q     <= '0;
    end else begin
      state_q   <= state_d;
      acc_cnt_q <= acc_cnt_d;
      wr_idx_q  <= wr_idx_d;
      ovf_q     <= ovf_d;
      num_q     <= num_d;
    end
  end

  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign overflow      = ovf_q;
  assign bad_point_num = num_q;
endmodule

// File: doc/bad_point_lut_writer.md
Name: bad_point_lut_writer

Overview:
- Producer side of the bad-point coordinate LUT that the manual dead-pixel replacement path consumes.
- Captures the coordinates of pixels flagged defective by the detection pipeline over one armed frame.
- Emits them as a raster-ordered stream of LUT write transactions in the existing (wen_lut, waddr_lut, wdata_lut) format.
- Reports the final count so it can be loaded into bad_point_num.

Parameters:
CNT_WIDTH, 10, width of the hcnt/vcnt coordinate counters
AXI_ADDR_WIDTH, 32, LUT write address width
AXI_DATA_WIDTH, 32, LUT write data width; must be ≥ 16+CNT_WIDTH
MAX_BP, 128, maximum number of LUT entries (index range 0..MAX_BP-1)
BP_BIT, 7, clog2(MAX_BP)
FIFO_DEPTH, 8, coordinate buffer depth; power of two

Ports:
aclk  in  1  single clock for all logic
areset  in  1  asynchronous active-high reset
arm  in  1  one-cycle request to capture the next frame
frame_start  in  1  one-cycle pulse at the first pixel of a frame
frame_end  in  1  one-cycle pulse after the last pixel of a frame
in_valid  in  1  pixel qualifier
in_hcnt  in  CNT_WIDTH  column of the current pixel
in_vcnt  in  CNT_WIDTH  row of the current pixel
defect_flag  in  1  current pixel is defective; qualified by in_valid
wr_ready  in  1  LUT side accepts the presented write
wen_lut  out  1  write valid
waddr_lut  out  AXI_ADDR_WIDTH  byte address, index*4
wdata_lut  out  AXI_DATA_WIDTH  {zeros, vcnt at [16+CNT_WIDTH-1:16], zeros, hcnt at [CNT_WIDTH-1:0]}
bad_point_num  out  8  number of entries written in the last completed capture
busy  out  1  state is not IDLE
done  out  1  one-cycle pulse when capture and drain complete
overflow  out  1  sticky flag: at least one defect was dropped in the last capture

Behaviour:
- Reset values: all outputs 0; state IDLE; FIFO empty; index 0; accept count 0. wen_lut falls asynchronously on areset, including in the middle of a transaction; any partially drained list is abandoned.
- FSM states:
  - IDLE: arm → ARMED. arm together with frame_start in the same cycle → CAPTURE directly, and that cycle's pixel is eligible. Entering ARMED or CAPTURE clears overflow, the accept count and the write index.
  - ARMED: frame_start → CAPTURE, and that cycle's pixel is eligible. arm is ignored.
  - CAPTURE: a defect is accepted when in_valid && defect_flag.
    - If accept count < MAX_BP and the FIFO is not full: push {vcnt, hcnt} and increment the accept count.
    - Otherwise: drop the defect and set overflow.
    - frame_end → DRAIN. A defect in the same cycle as frame_end is still processed.
  - DRAIN: wait until the FIFO is empty and no write is outstanding, then → DONE.
  - DONE: lasts one cycle. done=1; bad_point_num ← write index; then → IDLE.
- arm is ignored in every state except IDLE. frame_start while in CAPTURE is ignored; capture always ends on frame_end.
- Write handshake:
  - wen_lut=1 whenever the FIFO head is valid, in both CAPTURE and DRAIN.
  - waddr_lut and wdata_lut are registered from the head and stay stable while wen_lut && !wr_ready.
  - A transfer occurs on wen_lut && wr_ready. On a transfer: pop the FIFO and increment the write index. Back-to-back transfers at one per cycle are allowed.
  - The first write of a capture uses index 0. Write order equals raster acceptance order.
- FIFO:
  - A push and a pop in the same cycle are both honoured, including when the FIFO is full.
  - Full is evaluated before that cycle's pop, so a defect arriving while the FIFO is full is dropped even if a pop occurs in the same cycle.
- Width and limits: the accept count and write index are BP_BIT+1 bits. bad_point_num is zero-extended to 8 bits and never exceeds MAX_BP.
- Latency: a defect accepted in cycle N is presented at the earliest in cycle N+1 with wen_lut=1.
- The block never re-orders entries or deduplicates them; the upstream raster scan guarantees unique, ascending coordinates.

Decomposition:
- Shared package: the WDATA field offsets (VCNT_LSB=16, HCNT_LSB=0), the address stride of 4, and the FSM state encoding (IDLE, ARMED, CAPTURE, DRAIN, DONE).
- One sub-module: bp_coord_fifo. A synchronous first-word-fall-through FIFO, width 2*CNT_WIDTH, depth FIFO_DEPTH, with push, pop, full, empty and asynchronous active-high reset.
- The FSM, counters and write interface stay in the top module.

Test Plan:
- Single defect: arm, frame_start, then one defect at (h=5, v=3), wr_ready=1, then frame_end → one write with waddr=0x0 and wdata=0x0003_0005; done pulses; bad_point_num=1; overflow=0.
- Back-pressure: three consecutive defects at h=10,11,12 on v=7, with wr_ready held low for 5 cycles → wen_lut stays high with addr 0x0 and data stable; then writes to 0x0, 0x4, 0x8 in order; bad_point_num=3.
- Limit: 130 defects spread out (one per 4 pixels, wr_ready=1) → exactly 128 writes; last waddr=0x1FC; bad_point_num=128; overflow=1.
- FIFO overflow: 12 consecutive defects with wr_ready=0 → 8 accepted and 4 dropped; overflow=1; after releasing wr_ready, 8 writes occur and bad_point_num=8.
- Edge events: arm together with frame_start on a defective pixel (0,0), and a defect on the same cycle as frame_end → both are written; a second arm during DRAIN is ignored (no re-capture).
- Reset mid-drain: assert areset while wen_lut=1 → wen_lut, busy and done go 0 immediately; after release the state is IDLE and bad_point_num=0.
